itrx_amba3_apb_arb_master: RTL and testbench

//  Multi-requester AMBA3 APB master: round-robin arbitration of NREQ local

---
 rtl/itrx_amba3_apb_pkg.sv | 17 +
 rtl/itrx_rr_arb.sv | 43 ++++
 rtl/itrx_amba3_apb_arb_master.sv | 204 ++++++++++++++++++++
 tb/tb_itrx_amba3_apb_arb_master.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/itrx_amba3_apb_pkg.sv
// Shared types for the AMBA3 APB arbitrating master.
//   te_pwrite        : APB transfer direction (PWRITE encoding)
//   te_apb_arb_state : bus sequencer state (IDLE / SETUP / ACCESS)
package itrx_amba3_apb_pkg;

    typedef enum logic {
        TE_PWRITE_READ  = 1'b0,
        TE_PWRITE_WRITE = 1'b1
    } te_pwrite;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } te_apb_arb_state;

endpackage

// File: rtl/itrx_rr_arb.sv
// Round-robin arbiter: grants the first asserted request at or after the
// pointer position, wrapping around.
// Ports:
//   req [NREQ]  request vector
//   ptr [IW]    highest-priority index this cycle
//   gnt [NREQ]  one-hot grant (all zero when no request)
//   idx [IW]    index of the granted requester
//   any         at least one request pending
module itrx_rr_arb #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int              cand;
    logic            found;
    logic [NREQ-1:0] rot;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        rot   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            rot  = NREQ'(1) << cand;
            if (!found && |(req & rot)) begin
                found = 1'b1;
                idx   = IW'(cand);
                gnt   = rot;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/itrx_amba3_apb_arb_master.sv
// AMBA3 APB master shared by NREQ local requesters through round-robin
// arbitration. Sequences SETUP/ACCESS, returns PRDATA/PSLVERR to the
// requester that owned the transfer. Back-to-back transfers skip IDLE.
// Optional feature macro: ITRX_APB_ARB_TIMEOUT_EN (ACCESS-phase timeout of
// TMO_CYC cycles, reported as an error response).
// Ports:
//   pclk, prst                         clock, sync active-high reset
//   req_valid/req_ready [NREQ]         request handshake (ready = accept pulse)
//   req_write [NREQ], req_addr, req_wdata  per-requester transfer fields
//   rsp_valid [NREQ], rsp_rdata, rsp_err   one-cycle completion to requester
//   psel, penable, pwrite, paddr, pwdata   APB request side
//   prdata, pready, pslverr                APB completion side
import itrx_amba3_apb_pkg::*;

module itrx_amba3_apb_arb_master #(
    parameter int NREQ    = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TMO_CYC = 255
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [AW-1:0]     paddr,
    output logic [DW-1:0]     pwdata,
    input  logic [DW-1:0]     prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    te_apb_arb_state state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    te_pwrite        pwrite_q, pwrite_d;
    logic [AW-1:0]   paddr_q, paddr_d;
    logic [DW-1:0]   pwdata_q, pwdata_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;
    logic            accept;

    logic            sel_write;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;

    itrx_rr_arb #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req  (req_valid),
        .ptr  (ptr_q),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .any  (arb_any)
    );

    // Fields of the requester the arbiter currently selects.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

`ifdef ITRX_APB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_hit;

    // tmo_q holds the number of ACCESS cycles already completed, so the
    // TMO_CYC-th ACCESS cycle is the one where it equals TMO_CYC-1.
    assign tmo_hit = (state_q == ACCESS) && (tmo_q == TW'(TMO_CYC - 1));

    always_comb begin
        tmo_d = tmo_q;
        if (state_q == SETUP) begin
            tmo_d = '0;
        end else if (state_q == ACCESS) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        accept      = 1'b0;

        unique case (state_q)
            IDLE: begin
                accept = arb_any;
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    rsp_valid_d = NREQ'(1) << gidx_q;
                    rsp_rdata_d = (pwrite_q == TE_PWRITE_WRITE) ? '0 : prdata;
                    rsp_err_d   = pslverr;
                    // A waiting request goes straight to SETUP: psel stays high.
                    accept      = arb_any;
                    if (!arb_any) begin
                        state_d = IDLE;
                    end
                end
`ifdef ITRX_APB_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    rsp_valid_d = NREQ'(1) << gidx_q;
                    rsp_err_d   = 1'b1;
                    state_d     = IDLE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            state_d  = SETUP;
            gidx_d   = arb_idx;
            pwrite_d = te_pwrite'(sel_write);
            paddr_d  = sel_addr;
            pwdata_d = sel_wdata;
            ptr_d    = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gidx_q      <= '0;
            pwrite_q    <= TE_PWRITE_READ;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // The accept pulse is combinational; reset masks it so nothing is
    // claimed while the block is being cleared.
    assign req_ready = (accept && !prst) ? arb_gnt : '0;
    assign psel      = (state_q != IDLE);
    assign penable   = (state_q == ACCESS);
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_itrx_amba3_apb_arb_master.sv
// Bench for itrx_amba3_apb_arb_master: transaction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_itrx_amba3_apb_arb_master;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TMO  = 8;
`ifdef ITRX_APB_ARB_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic              pclk = 1'b0;
    logic              prst;
    logic [NREQ-1:0]   req_valid, req_ready, req_write, rsp_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [DW-1:0]     rsp_rdata, pwdata, prdata;
    logic              rsp_err, psel, penable, pwrite, pready, pslverr;
    logic [AW-1:0]     paddr;

    always #5 pclk = ~pclk;

    itrx_amba3_apb_arb_master #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .TMO_CYC(TMO)
    ) dut (
        .pclk(pclk), .prst(prst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- stimulus state ----------------
    int              rq_cnt [NREQ];
    logic [NREQ-1:0] acc_seen;
    int              acc_cnt;
    int              wait_n;

    // ---------------- observation logs ----------------
    int              cyc = 0;
    int              acc_cyc[$], acc_idx[$];
    int              rsp_cyc[$], rsp_idx[$];
    logic [DW-1:0]   rsp_dat[$];
    logic            rsp_er[$];
    int              su_cyc[$];
    logic [AW-1:0]   su_addr[$];
    logic [DW-1:0]   su_data[$];
    logic            su_wr[$];
    logic [AW-1:0]   watch_addr;
    int              watch_cnt;
    bit              b2b_mon;
    int              psel_low;

    // ---------------- reference model ----------------
    bit              model_on = 1'b0;
    bit              m_act;
    int              m_age, m_g, m_ptr, m_ridx;
    logic            m_w, m_rerr;
    logic [AW-1:0]   m_a;
    logic [DW-1:0]   m_d, m_rdat;
    bit              m_rsp;

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        logic [NREQ-1:0] s;
        for (int k = 0; k < NREQ; k++) begin
            s = v >> ((p + k) % NREQ);
            if (s[0]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    always @(negedge pclk) begin
        int p;
        bit can;
        logic [NREQ-1:0] e_rr, e_rv, wv;
        cyc++;
        acc_seen = req_ready;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin acc_cyc.push_back(cyc); acc_idx.push_back(i); end
            if (rsp_valid[i]) begin
                rsp_cyc.push_back(cyc); rsp_idx.push_back(i);
                rsp_dat.push_back(rsp_rdata); rsp_er.push_back(rsp_err);
            end
        end
        if (psel && !penable) begin
            su_cyc.push_back(cyc); su_addr.push_back(paddr);
            su_data.push_back(pwdata); su_wr.push_back(pwrite);
        end
        if (psel && penable && paddr == watch_addr) watch_cnt++;
        if (b2b_mon && acc_cyc.size() > 0 && rsp_cyc.size() < 4 && cyc > acc_cyc[0] && !psel)
            psel_low++;

        if (model_on) begin
            p    = pick(req_valid, m_ptr);
            can  = !prst && (!m_act || (m_age >= 2 && pready));
            e_rr = (can && p >= 0) ? (NREQ'(1) << p) : '0;
            e_rv = m_rsp ? (NREQ'(1) << m_ridx) : '0;
            chk("m_psel", psel, m_act);
            chk("m_penable", penable, m_act && m_age >= 2);
            chk("m_pwrite", pwrite, m_w);
            chk("m_paddr", paddr, m_a);
            chk("m_pwdata", pwdata, m_d);
            chk("m_req_ready", req_ready, e_rr);
            chk("m_rsp_valid", rsp_valid, e_rv);
            chk("m_rsp_rdata", rsp_rdata, m_rsp ? m_rdat : '0);
            chk("m_rsp_err", rsp_err, m_rsp ? m_rerr : 1'b0);

            m_rsp = 1'b0;
            if (m_act && m_age >= 2 && pready) begin
                m_rsp = 1'b1; m_ridx = m_g; m_rdat = m_w ? '0 : prdata;
                m_rerr = pslverr; m_act = 1'b0;
            end else if (TMO_ON && m_act && m_age - 1 == TMO) begin
                m_rsp = 1'b1; m_ridx = m_g; m_rdat = '0; m_rerr = 1'b1; m_act = 1'b0;
            end else if (m_act) begin
                m_age++;
            end
            if (can && p >= 0) begin
                wv = req_write >> p;
                m_act = 1'b1; m_age = 1; m_g = p; m_w = wv[0];
                m_a = req_addr[p*AW +: AW]; m_d = req_wdata[p*DW +: DW];
                m_ptr = (p + 1) % NREQ;
            end
        end
        if (prst) begin
            model_on = 1'b1; m_act = 1'b0; m_age = 0; m_ptr = 0; m_rsp = 1'b0;
            m_w = 1'b0; m_a = '0; m_d = '0; m_g = 0; m_ridx = 0; m_rdat = '0; m_rerr = 1'b0;
        end
    end

    // One clock of requester and slave behaviour.
    task automatic step();
        @(posedge pclk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc_seen[i] && rq_cnt[i] > 0) rq_cnt[i]--;
            req_valid[i] = (rq_cnt[i] > 0);
        end
        if (psel && penable) acc_cnt++;
        else acc_cnt = 0;
        pready = psel && penable && (acc_cnt > wait_n);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr_logs();
        acc_cyc.delete(); acc_idx.delete();
        rsp_cyc.delete(); rsp_idx.delete(); rsp_dat.delete(); rsp_er.delete();
        su_cyc.delete(); su_addr.delete(); su_data.delete(); su_wr.delete();
        watch_cnt = 0;
    endtask

    task automatic run_until_rsp(input int n, input int maxc, input string nm);
        int k;
        k = 0;
        while (rsp_cyc.size() < n && k < maxc) begin
            step();
            k++;
        end
        chk({nm, "_rsp_count"}, rsp_cyc.size(), n);
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[i] = w;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    initial begin
        prst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        acc_seen = '0; acc_cnt = 0; wait_n = 0; watch_addr = '1; watch_cnt = 0;
        b2b_mon = 1'b0; psel_low = 0;
        for (int i = 0; i < NREQ; i++) rq_cnt[i] = 0;

        // 1: reset with both requesters pending
        rq_cnt[0] = 1; rq_cnt[1] = 1;
        steps(4);
        chk("rst_psel", psel, 1'b0);
        chk("rst_penable", penable, 1'b0);
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        rq_cnt[0] = 0; rq_cnt[1] = 0;
        step();
        prst = 1'b0;
        steps(2);

        // 2: single zero-wait write from requester 0
        clr_logs();
        set_req(0, 1'b1, 32'h100, 32'hDEAD_BEEF);
        wait_n = 0; rq_cnt[0] = 1;
        run_until_rsp(1, 20, "wr");
        chk("wr_grant", acc_idx[0], 0);
        chk("wr_setup_lat", su_cyc[0] - acc_cyc[0], 1);
        chk("wr_setup_addr", su_addr[0], 32'h100);
        chk("wr_setup_data", su_data[0], 32'hDEAD_BEEF);
        chk("wr_setup_dir", su_wr[0], 1'b1);
        chk("wr_rsp_lat", rsp_cyc[0] - acc_cyc[0], 3);
        chk("wr_rsp_idx", rsp_idx[0], 0);
        chk("wr_rsp_rdata", rsp_dat[0], 32'h0);
        chk("wr_rsp_err", rsp_er[0], 1'b0);
        steps(2);

        // 3: read with four wait states from requester 1
        clr_logs();
        set_req(1, 1'b0, 32'h200, 32'h0);
        watch_addr = 32'h200; wait_n = 4; prdata = 32'h1234_5678; rq_cnt[1] = 1;
        run_until_rsp(1, 30, "ws");
        chk("ws_grant", acc_idx[0], 1);
        chk("ws_access_cycles", watch_cnt, 5);
        chk("ws_rsp_lat", rsp_cyc[0] - acc_cyc[0], 7);
        chk("ws_rsp_idx", rsp_idx[0], 1);
        chk("ws_rsp_rdata", rsp_dat[0], 32'h1234_5678);
        chk("ws_idle_psel", psel, 1'b0);
        steps(2);

        // 4: contention, two transfers queued on each requester
        clr_logs();
        set_req(0, 1'b1, 32'h400, 32'h0000_00A0);
        set_req(1, 1'b0, 32'h410, 32'h0);
        prdata = 32'h55; wait_n = 0; psel_low = 0; b2b_mon = 1'b1;
        rq_cnt[0] = 2; rq_cnt[1] = 2;
        run_until_rsp(4, 40, "rr");
        b2b_mon = 1'b0;
        chk("rr_g0", acc_idx[0], 0);
        chk("rr_g1", acc_idx[1], 1);
        chk("rr_g2", acc_idx[2], 0);
        chk("rr_g3", acc_idx[3], 1);
        chk("rr_spacing", acc_cyc[3] - acc_cyc[0], 6);
        chk("rr_total", rsp_cyc[3] - acc_cyc[0], 9);
        chk("rr_psel_low", psel_low, 0);
        chk("rr_rd_data", rsp_dat[1], 32'h55);
        steps(2);

        // 5: slave error, then reset while in ACCESS
        clr_logs();
        set_req(0, 1'b0, 32'h300, 32'h0);
        prdata = 32'hFFFF_0000; pslverr = 1'b1; wait_n = 0; rq_cnt[0] = 1;
        run_until_rsp(1, 20, "err");
        chk("err_rsp_err", rsp_er[0], 1'b1);
        chk("err_rsp_rdata", rsp_dat[0], 32'hFFFF_0000);
        pslverr = 1'b0;
        steps(2);
        clr_logs();
        wait_n = 1000; rq_cnt[0] = 1;
        begin
            int k;
            k = 0;
            while (!(psel && penable) && k < 20) begin step(); k++; end
        end
        chk("rstx_in_access", penable, 1'b1);
        step();
        prst = 1'b1;
        step();
        prst = 1'b0;
        chk("rstx_psel", psel, 1'b0);
        chk("rstx_penable", penable, 1'b0);
        steps(10);
        chk("rstx_no_rsp", rsp_cyc.size(), 0);
        // pointer returns to 0 after reset: requester 0 wins
        clr_logs(); wait_n = 0;
        rq_cnt[0] = 1; rq_cnt[1] = 1;
        run_until_rsp(2, 20, "ptr");
        chk("ptr_first_grant", acc_idx[0], 0);
        steps(2);

        // 6: ACCESS never completes
        clr_logs();
        set_req(1, 1'b0, 32'h600, 32'h0);
        watch_addr = 32'h600; wait_n = 100000; prdata = 32'hABCD; rq_cnt[1] = 1;
`ifdef ITRX_APB_ARB_TIMEOUT_EN
        run_until_rsp(1, 40, "tmo");
        chk("tmo_access_cycles", watch_cnt, TMO);
        chk("tmo_rsp_lat", rsp_cyc[0] - acc_cyc[0], TMO + 2);
        chk("tmo_rsp_idx", rsp_idx[0], 1);
        chk("tmo_rsp_err", rsp_er[0], 1'b1);
        chk("tmo_rsp_rdata", rsp_dat[0], 32'h0);
        chk("tmo_psel_after", psel, 1'b0);
`else
        steps(100);
        chk("notmo_no_rsp", rsp_cyc.size(), 0);
        chk("notmo_still_access", penable, 1'b1);
        prst = 1'b1;
        step();
        prst = 1'b0;
`endif
        steps(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
